// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its matching decoder:
// constraint-length limits, FSM states, generator tables and small helper functions.
package conv_pkg;

  localparam int KMAX      = 6;
  localparam int DEFAULT_K = 3;
  localparam int SRW       = KMAX - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  // Generators left-justified in 6 bits (bit 5 = current input), indexed by K; unused entries are zero.
  localparam logic [7:0][5:0] G0 = {6'b000000, 6'b101011, 6'b100110, 6'b111100,
                                    6'b111000, 6'b000000, 6'b000000, 6'b000000};
  localparam logic [7:0][5:0] G1 = {6'b000000, 6'b111101, 6'b111010, 6'b110100,
                                    6'b101000, 6'b000000, 6'b000000, 6'b000000};

  function automatic logic k_is_valid(input logic [2:0] k);
    return (k >= 3'd3) && (k <= 3'd6);
  endfunction

  function automatic logic [2:0] sanitize_k(input logic [2:0] k);
    return k_is_valid(k) ? k : 3'(DEFAULT_K);
  endfunction

  function automatic logic parity6(input logic [5:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_sym_gen.sv
// Combinational symbol generator: maps the current input bit, shift register and K
// to one coded symbol {g0, g1}. Shared with the decoder's expected-output logic.
module conv_sym_gen
  import conv_pkg::*;
(
  input  logic           u,
  input  logic [SRW-1:0] sr,
  input  logic [2:0]     k,
  output logic [1:0]     sym
);

  logic [5:0] w;

  // Window runs newest to oldest: current input, then sr[0] (most recent) down to sr[4].
  assign w   = {u, sr[0], sr[1], sr[2], sr[3], sr[4]};
  assign sym = {parity6(w & G0[k]), parity6(w & G1[k])};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder, K = 3..6 chosen per frame, with K-1
// zero tail symbols per frame and a single registered output stage.
module conv_encoder
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] k_sel,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_bits,
  output logic       out_last,
  output logic       cfg_err
);

  enc_state_t     state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [2:0]     k_q, k_d;
  logic [2:0]     tail_cnt_q, tail_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [1:0]     out_bits_q, out_bits_d;
  logic           out_last_q, out_last_d;
  logic           cfg_err_q, cfg_err_d;

  logic       adv;
  logic       sym_u;
  logic [2:0] sym_k;
  logic [1:0] sym;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = !rst && adv && (state_q != TAIL);

  conv_sym_gen u_sym_gen (
    .u   (sym_u),
    .sr  (sr_q),
    .k   (sym_k),
    .sym (sym)
  );

  // Next-state, shift register and output-stage update.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    k_d         = k_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;
    cfg_err_d   = 1'b0;
    sym_u       = 1'b0;
    sym_k       = k_q;

    if (adv) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        sym_u = in_bit;
        sym_k = sanitize_k(k_sel);
        if (in_valid && adv) begin
          k_d         = sym_k;
          cfg_err_d   = !k_is_valid(k_sel);
          out_valid_d = 1'b1;
          out_bits_d  = sym;
          sr_d        = {sr_q[SRW-2:0], in_bit};
          if (in_last) begin
            state_d    = TAIL;
            tail_cnt_d = sym_k - 3'd2;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        sym_u = in_bit;
        if (in_valid && adv) begin
          out_valid_d = 1'b1;
          out_bits_d  = sym;
          sr_d        = {sr_q[SRW-2:0], in_bit};
          if (in_last) begin
            state_d    = TAIL;
            tail_cnt_d = k_q - 3'd2;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      TAIL: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_bits_d  = sym;
          if (tail_cnt_q == 3'd0) begin
            // Final flush symbol: leave the trellis in state 0 for the next frame.
            out_last_d = 1'b1;
            sr_d       = '0;
            state_d    = IDLE;
          end else begin
            sr_d       = {sr_q[SRW-2:0], 1'b0};
            tail_cnt_d = tail_cnt_q - 3'd1;
          end
        end else begin
          state_d = TAIL;
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      k_q         <= 3'(DEFAULT_K);
      tail_cnt_q  <= 3'd0;
      out_valid_q <= 1'b0;
      out_bits_q  <= 2'b00;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      k_q         <= k_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2 feed-forward convolutional encoder; the transmit-side counterpart of decoder_sys.
- Accepts one information bit per handshake and emits one 2-bit coded symbol per bit.
- Appends K-1 zero tail symbols per frame so the trellis terminates in state 0.
- Constraint length K = 3..6 is selected per frame; symbol bit order and state convention match the decoder's trellis tables.

Parameters:
- KMAX, 6, largest supported constraint length; shift register is KMAX-1 = 5 bits.
- DEFAULT_K, 3, K used when k_sel is out of range.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- k_sel  input  3  constraint length 3..6; sampled only on the first accepted bit of a frame
- in_valid  input  1  in_bit/in_last valid
- in_ready  output  1  encoder accepts input this cycle
- in_bit  input  1  information bit
- in_last  input  1  marks final information bit of frame
- out_valid  output  1  out_bits valid
- out_ready  input  1  downstream accepts symbol
- out_bits  output  2  coded symbol; [1] = generator g0, [0] = generator g1
- out_last  output  1  marks final tail symbol of frame
- cfg_err  output  1  one-cycle pulse: frame started with k_sel outside 3..6

Behaviour:
- Reset (async, rst=1): state IDLE; sr = 0; k_reg = DEFAULT_K; tail_cnt = 0; out_valid = 0; out_bits = 00; out_last = 0; cfg_err = 0; in_ready = 0 while rst is high.
- Advance condition: adv = !out_valid || out_ready. Single registered output stage; symbol appears the cycle after its bit is accepted (latency 1).
- Throughput: one symbol per cycle under continuous out_ready.
- in_ready = adv when state is IDLE or DATA; in_ready = 0 in TAIL.
- Window w[5:0]: w[5] = u (current input), w[4] = sr[0] (most recent bit), ... w[0] = sr[4] (oldest bit).
- Code bits: out_bits[1] = ^(w & G0[K]), out_bits[0] = ^(w & G1[K]).
- Polynomials are left-justified in 6 bits, from octal:
  - K=3: (7,5) -> 111000, 101000
  - K=4: (17,15) -> 111100, 110100
  - K=5: (23,35) -> 100110, 111010
  - K=6: (53,75) -> 101011, 111101
- Shift on each emitted symbol: sr <= {sr[3:0], u}.
- Trellis state = {sr[0], sr[1]} for K=3, i.e. {newest, oldest}. This matches the decoder's table: state 1 input 0 -> 11.
- FSM:
  - IDLE: on accept, k_reg <= sanitized k_sel and emit symbol using the sanitized K combinationally. If k_sel is invalid, cfg_err pulses in the same cycle the symbol registers. Next: in_last ? TAIL (tail_cnt = K-2) : DATA.
  - DATA: on accept, emit symbol using k_reg. On in_last: TAIL with tail_cnt = k_reg-2.
  - TAIL: on adv, emit symbol with u = 0. At tail_cnt = 0, set out_last = 1, clear sr fully and go to IDLE; otherwise tail_cnt decrements.
- Sanitize: k_sel in {3,4,5,6} is used as-is; any other value is treated as DEFAULT_K.
- k_sel changes mid-frame are ignored until the next IDLE accept.
- Hold rule: while out_valid && !out_ready, out_bits and out_last hold stable and no FSM or sr change occurs.
- Back-to-back frames: IDLE can accept a new first bit in the cycle immediately after the final tail symbol is registered, provided adv is true.
- Reset mid-frame: frame is aborted; no out_last is generated; the next frame starts from sr = 0.
- No internal bubbles: with in_valid and out_ready held at 1, a frame of N bits yields N+K-1 symbols on consecutive cycles.

Decomposition:
- Shared package conv_pkg:
  - KMAX, DEFAULT_K
  - enum enc_state_t {IDLE, DATA, TAIL}
  - G0/G1 polynomial constant arrays indexed by K
  - function sanitize_k
  - function parity6
- decoder_sys is to use the same package so that the tables match.
- One natural sub-module: conv_sym_gen. It is combinational: inputs u, sr and K; output the 2-bit symbol. It is reusable by the decoder's branch-metric expected-output logic.

Test Plan:
- K=3, bits 1,0,1,1 (last on 4th), out_ready=1 -> symbols 11,10,00,01,01,11; out_last only on the 6th; returns to IDLE.
- K=4, single bit 1 with in_last -> impulse response 11,11,10,11; out_last on the 4th.
- K=3 stream with out_ready toggled 1,0,0,1,... -> out_bits stable while stalled; no lost or duplicated symbols; sequence identical to the unstalled run.
- k_sel=7 at frame start -> cfg_err pulses once; encoding equals K=3. Changing k_sel to 5 mid-frame -> no effect until the next frame.
- Reset asserted during the TAIL of a K=6 frame -> out_valid=0 immediately. The next frame with K=3 and bit 1 last gives 11,10,11 from a clean state.
- Two back-to-back K=5 frames with in_valid held high -> no bubble between the first frame's out_last and the second frame's first symbol; the second frame's impulse response is 11,01,01,10,11.
